rgy_monitor: RTL and testbench

- Receive-side checker for the two-way traffic-light output pair `rgy0`/`rgy1` produced by the intersection light controller.
- Each clock it decodes the light pattern into a phase and tracks phase order and dwell length.
- It raises sticky error flags on unsafe or out-of-spec behaviour.
- It sits next to the light controller as a safety watchdog and as a bench scoreboard.

---
 rtl/rgy_monitor_if.sv | 32 +++
 rtl/rgy_monitor.sv | 183 ++++++++++++++++++
 tb/tb_rgy_monitor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rgy_monitor_if.sv
// rgy_monitor_if: bundles the light pair under test, the error-clear request
// and the monitor's status outputs.
//   rgy0, rgy1   : lamp vectors {unused, GREEN, YELLOW, RED} of lights 0 and 1
//   clr_err      : synchronous clear of the sticky error flags
//   phase        : last legal decoded phase (0 G1, 1 Y1, 2 G0, 3 Y0)
//   phase_valid  : last sample was a legal pattern
//   locked       : monitor is tracking a verified phase rotation
//   err          : sticky flags [0] pattern, [1] conflict, [2] sequence, [3] dwell
//   err_pulse    : one-cycle strobe on any new detection
//   cycles_done  : completed full rotations (zero unless the counter is built)
// master drives the lights (controller side / bench); slave is the monitor.
interface rgy_monitor_if;
  logic [3:0]  rgy0;
  logic [3:0]  rgy1;
  logic        clr_err;
  logic [1:0]  phase;
  logic        phase_valid;
  logic        locked;
  logic [3:0]  err;
  logic        err_pulse;
  logic [15:0] cycles_done;

  modport master (
    output rgy0, rgy1, clr_err,
    input  phase, phase_valid, locked, err, err_pulse, cycles_done
  );

  modport slave (
    input  rgy0, rgy1, clr_err,
    output phase, phase_valid, locked, err, err_pulse, cycles_done
  );
endinterface

// File: rtl/rgy_monitor.sv
// rgy_monitor: receive-side safety checker for a two-way traffic light pair.
// Each cycle the {rgy0, rgy1} sample is decoded into a phase; the monitor
// tracks phase order (G1 -> Y1 -> G0 -> Y0 -> G1) and dwell length and raises
// sticky error flags on unsafe or out-of-order behaviour. All outputs are
// registered, so results appear one cycle after the sample.
// Ports:
//   clk    : clock, all updates on posedge
//   reset  : asynchronous, active-low reset
//   mon    : rgy_monitor_if.slave (lights in, status/error flags out)
// Parameters: GREEN_CYC / YELLOW_CYC required dwell, CNT_W dwell counter width
// (2**CNT_W-1 must exceed GREEN_CYC).
// Optional feature: define RGY_MON_CYCLE_CNT_EN to build the 16-bit rotation
// counter on cycles_done; otherwise cycles_done is tied to zero.
module rgy_monitor #(
  parameter int unsigned GREEN_CYC  = 6,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic         clk,
  input  logic         reset,
  rgy_monitor_if.slave mon
);

  localparam int unsigned ERR_W = 4;
  localparam int unsigned PH_W  = 2;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_EXP  = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] YELLOW_EXP = CNT_W'(YELLOW_CYC);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               valid_q;
  logic               locked_q;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pulse_q;
  logic [ERR_W-1:0]   flags;

  logic               legal;
  logic [PH_W-1:0]    smp_phase;
  logic               conflict;
  logic               is_same;
  logic               is_succ;
  logic [CNT_W-1:0]   exp_dwell;
  logic [CNT_W-1:0]   dwell_inc;

  // Decode the sampled lamp pair into one of the four legal phases.
  always_comb begin
    legal     = 1'b0;
    smp_phase = '0;
    case ({mon.rgy0, mon.rgy1})
      8'b0001_0100: begin legal = 1'b1; smp_phase = 2'd0; end
      8'b0001_0010: begin legal = 1'b1; smp_phase = 2'd1; end
      8'b0100_0001: begin legal = 1'b1; smp_phase = 2'd2; end
      8'b0010_0001: begin legal = 1'b1; smp_phase = 2'd3; end
      default:      begin legal = 1'b0; smp_phase = '0;   end
    endcase
  end

  // Both lights off red is the dangerous case and outranks a plain bad pattern.
  assign conflict  = ~mon.rgy0[0] & ~mon.rgy1[0];
  assign is_same   = (smp_phase == phase_q);
  assign is_succ   = (smp_phase == phase_q + PH_W'(1));
  // Odd phase codes are the yellow phases.
  assign exp_dwell = phase_q[0] ? YELLOW_EXP : GREEN_EXP;
  assign dwell_inc = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_ONE;

  // Next-state, dwell tracking and error detection.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    flags   = '0;
    case (state_q)
      UNSYNC: begin
        if (legal) begin
          state_d = ALIGN;
          phase_d = smp_phase;
          dwell_d = CNT_ONE;
        end else begin
          dwell_d = '0;
        end
      end
      ALIGN: begin
        if (!legal) begin
          // Legal traffic has already been seen, so a bad sample is reported.
          state_d = UNSYNC;
          dwell_d = '0;
          if (conflict) flags[1] = 1'b1;
          else          flags[0] = 1'b1;
        end else if (is_same) begin
          dwell_d = dwell_inc;
        end else begin
          if (is_succ) state_d = LOCKED;
          phase_d = smp_phase;
          dwell_d = CNT_ONE;
        end
      end
      LOCKED: begin
        if (!legal) begin
          state_d = UNSYNC;
          dwell_d = '0;
          if (conflict) flags[1] = 1'b1;
          else          flags[0] = 1'b1;
        end else if (is_same) begin
          // Sample expected+1 of the same phase is the overstay; flagged once.
          if (dwell_q == exp_dwell) flags[3] = 1'b1;
          dwell_d = dwell_inc;
        end else if (is_succ) begin
          // A count above expected was already flagged as an overstay.
          if (dwell_q < exp_dwell) flags[3] = 1'b1;
          phase_d = smp_phase;
          dwell_d = CNT_ONE;
        end else begin
          flags[2] = 1'b1;
          state_d  = ALIGN;
          phase_d  = smp_phase;
          dwell_d  = CNT_ONE;
        end
      end
      default: begin
        state_d = UNSYNC;
        dwell_d = '0;
      end
    endcase
  end

  // New detections win over a simultaneous clear.
  assign err_d = (mon.clr_err ? '0 : err_q) | flags;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= UNSYNC;
      phase_q  <= '0;
      dwell_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      valid_q  <= legal;
      locked_q <= (state_d == LOCKED);
      err_q    <= err_d;
      pulse_q  <= |flags;
    end
  end

  assign mon.phase       = phase_q;
  assign mon.phase_valid = valid_q;
  assign mon.locked      = locked_q;
  assign mon.err         = err_q;
  assign mon.err_pulse   = pulse_q;

`ifdef RGY_MON_CYCLE_CNT_EN
  logic        rot_done;
  logic [15:0] cyc_q;

  // A clean Y0 -> G1 step while locked closes one full rotation.
  assign rot_done = (state_q == LOCKED) && legal && (phase_q == 2'd3) &&
                    (smp_phase == 2'd0) && (flags == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cyc_q <= '0;
    else if (rot_done) cyc_q <= cyc_q + 16'd1;
  end

  assign mon.cycles_done = cyc_q;
`else
  assign mon.cycles_done = '0;
`endif

endmodule

// File: tb/tb_rgy_monitor.sv
// tb_rgy_monitor: directed scenarios plus randomized light traffic for
// rgy_monitor, checked every cycle against a phase-level reference model.
module tb_rgy_monitor;

  localparam int unsigned GREEN  = 6;
  localparam int unsigned YELLOW = 2;
  localparam int unsigned RAND_CYCLES = 4000;

  logic clk;
  logic reset;
  rgy_monitor_if mif ();

  rgy_monitor #(.GREEN_CYC(GREEN), .YELLOW_CYC(YELLOW), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Legal {rgy0, rgy1} patterns indexed by phase: G1, Y1, G0, Y0.
  logic [7:0] legal_pat [4] = '{8'b0001_0100, 8'b0001_0010, 8'b0100_0001, 8'b0010_0001};

  int vectors;
  int miscompares;

  // Reference model: sync level 0 = not synced, 1 = aligning, 2 = locked.
  int          sync_level;
  int          m_phase;
  int          run_len;
  logic        m_valid;
  logic [3:0]  m_err;
  logic        m_pulse;
  int          m_rot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int req_dwell(input int p);
    return (p % 2 == 1) ? YELLOW : GREEN;
  endfunction

  task automatic model_reset();
    sync_level = 0; m_phase = 0; run_len = 0;
    m_valid = 1'b0; m_err = '0; m_pulse = 1'b0; m_rot = 0;
  endtask

  task automatic model_step(input logic [3:0] r0, input logic [3:0] r1, input logic clr);
    int idx;
    logic [3:0] fl;
    logic [7:0] pat;
    idx = -1;
    fl  = '0;
    pat = {r0, r1};
    for (int p = 0; p < 4; p++) if (pat == legal_pat[p]) idx = p;
    if (idx < 0) begin
      if (sync_level != 0) fl = (r0[0] || r1[0]) ? 4'b0001 : 4'b0010;
      sync_level = 0;
      run_len = 0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      if (sync_level == 0) begin
        sync_level = 1; m_phase = idx; run_len = 1;
      end else if (idx == m_phase) begin
        if (sync_level == 2 && run_len == req_dwell(m_phase)) fl = 4'b1000;
        run_len++;
      end else if (idx == (m_phase + 1) % 4) begin
        if (sync_level == 2) begin
          if (run_len < req_dwell(m_phase)) fl = 4'b1000;
          if (m_phase == 3 && fl == 0) m_rot++;
        end
        sync_level = 2; m_phase = idx; run_len = 1;
      end else begin
        if (sync_level == 2) begin fl = 4'b0100; sync_level = 1; end
        m_phase = idx; run_len = 1;
      end
    end
    m_err   = (clr ? 4'b0000 : m_err) | fl;
    m_pulse = (fl != 0);
  endtask

  task automatic compare_all();
    check("phase",       32'(mif.phase),       32'(m_phase));
    check("phase_valid", 32'(mif.phase_valid), 32'(m_valid));
    check("locked",      32'(mif.locked),      32'(sync_level == 2));
    check("err",         32'(mif.err),         32'(m_err));
    check("err_pulse",   32'(mif.err_pulse),   32'(m_pulse));
`ifdef RGY_MON_CYCLE_CNT_EN
    check("cycles_done", 32'(mif.cycles_done), 32'(m_rot % 65536));
`else
    check("cycles_done", 32'(mif.cycles_done), 32'(0));
`endif
  endtask

  task automatic apply(input logic [3:0] r0, input logic [3:0] r1, input logic clr);
    mif.rgy0 = r0; mif.rgy1 = r1; mif.clr_err = clr;
    @(posedge clk);
    model_step(r0, r1, clr);
    #1;
    compare_all();
  endtask

  task automatic drive_phase(input int p, input int n, input logic clr);
    logic [7:0] pat;
    pat = legal_pat[p];
    for (int i = 0; i < n; i++) apply(pat[7:4], pat[3:0], clr);
  endtask

  task automatic nominal_rotation();
    drive_phase(0, GREEN, 1'b0);
    drive_phase(1, YELLOW, 1'b0);
    drive_phase(2, GREEN, 1'b0);
    drive_phase(3, YELLOW, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},  32'(mif.phase),       32'(0));
    check({tag, "_valid"},  32'(mif.phase_valid), 32'(0));
    check({tag, "_locked"}, 32'(mif.locked),      32'(0));
    check({tag, "_err"},    32'(mif.err),         32'(0));
    check({tag, "_pulse"},  32'(mif.err_pulse),   32'(0));
    check({tag, "_cycles"}, 32'(mif.cycles_done), 32'(0));
  endtask

  initial begin
    int walk_ph;
    int walk_left;
    int r;
    logic [7:0] rnd;
    logic clr;
    vectors = 0;
    miscompares = 0;
    model_reset();
    reset = 1'b0;
    mif.rgy0 = '0; mif.rgy1 = '0; mif.clr_err = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Nominal rotations: lock after first G1 -> Y1, never an error.
    drive_phase(0, GREEN, 1'b0);
    drive_phase(1, 1, 1'b0);
    check("lock_after_g1y1", 32'(mif.locked), 32'(1));
    drive_phase(1, YELLOW - 1, 1'b0);
    drive_phase(2, GREEN, 1'b0);
    drive_phase(3, YELLOW, 1'b0);
    nominal_rotation();
    nominal_rotation();
    check("nominal_err", 32'(mif.err), 32'(0));
`ifdef RGY_MON_CYCLE_CNT_EN
    check("nominal_cycles", 32'(mif.cycles_done), 32'(2));
`else
    check("nominal_cycles", 32'(mif.cycles_done), 32'(0));
`endif

    // Conflict while locked.
    apply(4'b0100, 4'b0100, 1'b0);
    check("conflict_err",    32'(mif.err),         32'(4'b0010));
    check("conflict_pulse",  32'(mif.err_pulse),   32'(1));
    check("conflict_valid",  32'(mif.phase_valid), 32'(0));
    check("conflict_locked", 32'(mif.locked),      32'(0));
    drive_phase(0, 1, 1'b1);
    check("conflict_pulse_once", 32'(mif.err_pulse), 32'(0));
    check("clr_after_conflict",  32'(mif.err),       32'(0));

    // Sequence jump G1 -> G0 while locked, then relock on G0 -> Y0.
    drive_phase(0, GREEN - 1, 1'b0);
    drive_phase(1, YELLOW, 1'b0);
    drive_phase(2, GREEN, 1'b0);
    drive_phase(3, YELLOW, 1'b0);
    drive_phase(0, 3, 1'b0);
    drive_phase(2, 1, 1'b0);
    check("jump_err2",   32'(mif.err[2]), 32'(1));
    check("jump_locked", 32'(mif.locked), 32'(0));
    drive_phase(2, GREEN - 1, 1'b0);
    drive_phase(3, 1, 1'b0);
    check("relock", 32'(mif.locked), 32'(1));
    drive_phase(3, YELLOW - 1, 1'b1);

    // Overstay of G1 by one cycle, then a short Y1.
    drive_phase(0, GREEN + 1, 1'b0);
    check("overstay_err3",  32'(mif.err[3]),   32'(1));
    check("overstay_pulse", 32'(mif.err_pulse), 32'(1));
    drive_phase(1, 1, 1'b0);
    check("overstay_exit_pulse", 32'(mif.err_pulse), 32'(0));
    drive_phase(2, 1, 1'b0);
    check("short_y1_err3",  32'(mif.err[3]),   32'(1));
    check("short_y1_pulse", 32'(mif.err_pulse), 32'(1));

    // Clear and conflict in the same cycle: the detection wins.
    drive_phase(2, 1, 1'b1);
    check("clr_legal", 32'(mif.err), 32'(0));
    apply(4'b0000, 4'b0010, 1'b1);
    check("clr_vs_conflict", 32'(mif.err), 32'(4'b0010));
    apply(4'b0000, 4'b0000, 1'b1);
    check("clr_alone", 32'(mif.err), 32'(0));

    // Asynchronous reset in the middle of G0.
    drive_phase(0, 2, 1'b0);
    drive_phase(1, YELLOW, 1'b0);
    drive_phase(2, 3, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset");
    #2;
    reset = 1'b1;
    drive_phase(2, 2, 1'b0);
    check("post_reset_unlocked", 32'(mif.locked), 32'(0));
    drive_phase(3, 1, 1'b0);
    check("post_reset_lock", 32'(mif.locked), 32'(1));

    // Randomized traffic: mostly a walking rotation with perturbations.
    walk_ph = 0;
    walk_left = GREEN;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      r   = int'($urandom_range(0, 99));
      clr = ($urandom_range(0, 19) == 0);
      if (r < 4) begin
        rnd = 8'($urandom);
        apply(rnd[7:4], rnd[3:0], clr);
      end else if (r < 7) begin
        walk_ph = int'($urandom_range(0, 3));
        walk_left = int'($urandom_range(1, 8));
        rnd = legal_pat[walk_ph];
        apply(rnd[7:4], rnd[3:0], clr);
      end else begin
        rnd = legal_pat[walk_ph];
        apply(rnd[7:4], rnd[3:0], clr);
        walk_left--;
        if (walk_left <= 0) begin
          walk_ph = (walk_ph + 1) % 4;
          if ($urandom_range(0, 9) < 8) walk_left = req_dwell(walk_ph);
          else walk_left = int'($urandom_range(1, 8));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
